// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest read-out path.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int CNT_W     = 3;

  typedef logic [WORD_W-1:0]           word_t;
  typedef logic [NUM_WORDS*WORD_W-1:0] digest_t;

  // Read-out FSM: waiting for a digest, or streaming one out.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_t;

endpackage

// File: rtl/sha256_digest_shift_reg.sv
// Parallel-load, word-shift-left holding register for a captured digest.
// The top word is always the word currently on the output bus; shifting in
// zeros means the register is empty again once the last word has left.
module sha256_digest_shift_reg #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        shift,
  input  logic [NUM_WORDS*WORD_W-1:0] data_in,
  output logic [WORD_W-1:0]           top_word
);

  localparam int TOTAL_W = NUM_WORDS * WORD_W;

  logic [TOTAL_W-1:0] data_r;

  // Holding register: flush beats capture, capture beats shift.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_r <= {TOTAL_W{1'b0}};
    end else if (clear) begin
      data_r <= {TOTAL_W{1'b0}};
    end else if (load) begin
      data_r <= data_in;
    end else if (shift) begin
      data_r <= {data_r[TOTAL_W-WORD_W-1:0], {WORD_W{1'b0}}};
    end else begin
      data_r <= data_r;
    end
  end

  assign top_word = data_r[TOTAL_W-1 -: WORD_W];

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures a finished SHA-256 digest and streams it out as H0..H7 over a
// valid/ready word interface. Digests offered while streaming are dropped
// and flagged with a one-cycle overrun pulse.
module sha256_digest_streamer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clear_i,
  input  logic                        digest_valid_i,
  input  logic [NUM_WORDS*WORD_W-1:0] digest_i,
  output logic                        digest_ready_o,
  output logic [WORD_W-1:0]           word_o,
  output logic                        word_valid_o,
  input  logic                        word_ready_i,
  output logic                        word_last_o,
  output logic [CNT_W-1:0]            word_idx_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  import sha256_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_IDX = CNT_W'(0);

  stream_state_t    state_r, state_s;
  logic [CNT_W-1:0] idx_r, idx_s;
  logic             last_r, last_s;
  logic             overrun_r, overrun_s;
  logic             load_s, shift_s;
  logic [WORD_W-1:0] top_word_s;

  sha256_digest_shift_reg #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_shift_reg (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (clear_i),
    .load     (load_s),
    .shift    (shift_s),
    .data_in  (digest_i),
    .top_word (top_word_s)
  );

  // State, word index, last-word flag and overrun pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      idx_r     <= ZERO_IDX;
      last_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      last_r    <= last_s;
      overrun_r <= overrun_s;
    end
  end

  // Next-state logic: capture in IDLE, advance on each handshake in SEND,
  // with the flush overriding both.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    overrun_s = digest_valid_i && (state_r == SEND);
    if (clear_i) begin
      state_s = IDLE;
      idx_s   = ZERO_IDX;
    end else begin
      case (state_r)
        IDLE: begin
          if (digest_valid_i) begin
            load_s  = 1'b1;
            state_s = SEND;
            idx_s   = ZERO_IDX;
          end else begin
            state_s = IDLE;
          end
        end
        SEND: begin
          if (word_ready_i) begin
            shift_s = 1'b1;
            if (idx_r == LAST_IDX) begin
              state_s = IDLE;
              idx_s   = ZERO_IDX;
            end else begin
              idx_s = idx_r + ONE_IDX;
            end
          end else begin
            state_s = SEND;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = ZERO_IDX;
        end
      endcase
    end
    last_s = (state_s == SEND) && (idx_s == LAST_IDX);
  end

  assign digest_ready_o = (state_r == IDLE);
  assign word_valid_o   = (state_r == SEND);
  assign busy_o         = (state_r == SEND);
  assign word_o         = top_word_s;
  assign word_last_o    = last_r;
  assign word_idx_o     = idx_r;
  assign overrun_o      = overrun_r;

endmodule
